// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with one-hot operation select.
//
// Logic ops and binary add finish in one cycle. A right shift walks one bit per
// cycle in RUN_SR; a decimal add walks one BCD nibble per cycle in RUN_DEC.
// A multi-cycle op holds sig_BUSY for its step count (SHAMT or WIDTH/4 cycles).
// sig_DONE then pulses on the edge that returns the FSM to IDLE.
//
// Build option: define ALU_DECIMAL_EN to compile in the decimal (BCD) add.
// Without it, sig_DAA is ignored and every add is binary.
//
// Ports:
//   sig_CLK, sig_RST_N          clock, synchronous active-low reset
//   sig_START                   op request, sampled only in IDLE
//   sig_SUMS/ANDS/EORS/ORS/SRS  one-hot op select (add, and, xor, or, shift right)
//   sig_DAA                     decimal modifier for add
//   sig_CARRY_IN, sig_SHAMT     add carry-in, shift distance
//   reg_A, reg_B                operands
//   ALU_OUT                     registered result
//   sig_AVR, sig_ACR, sig_HC    overflow, carry/shift-out, half-carry
//   sig_BUSY, sig_DONE, sig_ERR busy level, done pulse, illegal-select pulse
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             sig_CLK,
  input  logic             sig_RST_N,
  input  logic             sig_START,
  input  logic             sig_SUMS,
  input  logic             sig_ANDS,
  input  logic             sig_EORS,
  input  logic             sig_ORS,
  input  logic             sig_SRS,
  input  logic             sig_DAA,
  input  logic             sig_CARRY_IN,
  input  logic [SHW-1:0]   sig_SHAMT,
  input  logic [WIDTH-1:0] reg_A,
  input  logic [WIDTH-1:0] reg_B,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             sig_AVR,
  output logic             sig_ACR,
  output logic             sig_HC,
  output logic             sig_BUSY,
  output logic             sig_DONE,
  output logic             sig_ERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN_SR = 2'd1;
`ifdef ALU_DECIMAL_EN
  localparam logic [1:0] RUN_DEC = 2'd2;
  localparam int unsigned NumNib = WIDTH / 4;
`endif

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             avr_q, avr_d, acr_q, acr_d, hc_q, hc_d;
  logic             done_q, done_d, err_q, err_d;

  logic [4:0]       sel;
  logic             sel_ok;
  logic [WIDTH:0]   bin_sum;
  logic [4:0]       low_sum;
  logic             bin_ovf;

  assign sel     = {sig_SUMS, sig_ANDS, sig_EORS, sig_ORS, sig_SRS};
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_ok  = (sel != 5'd0) && ((sel & (sel - 5'd1)) == 5'd0);
  assign bin_sum = {1'b0, reg_A} + {1'b0, reg_B} + {{WIDTH{1'b0}}, sig_CARRY_IN};
  assign low_sum = {1'b0, reg_A[3:0]} + {1'b0, reg_B[3:0]} + {4'd0, sig_CARRY_IN};
  assign bin_ovf = (reg_A[WIDTH-1] == reg_B[WIDTH-1]) &&
                   (bin_sum[WIDTH-1] != reg_A[WIDTH-1]);

`ifdef ALU_DECIMAL_EN
  // Operands are shifted down a nibble per step; digits enter work_q from the top.
  logic [WIDTH-1:0] da_q, da_d, db_q, db_d;
  logic             dc_q, dc_d, dhc_q, dhc_d, dovf_q, dovf_d;
  logic [4:0]       nib_sum;
  logic [3:0]       nib_digit;
  logic             nib_carry;
  logic [WIDTH+3:0] dec_cat;

  always_comb begin
    nib_sum   = {1'b0, da_q[3:0]} + {1'b0, db_q[3:0]} + {4'd0, dc_q};
    nib_carry = (nib_sum > 5'd9);
    nib_digit = nib_carry ? (nib_sum[3:0] + 4'd6) : nib_sum[3:0];
    dec_cat   = {nib_digit, work_q};
  end
`else
  logic unused_daa;
  assign unused_daa = sig_DAA;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    avr_d   = avr_q;
    acr_d   = acr_q;
    hc_d    = hc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef ALU_DECIMAL_EN
    da_d    = da_q;
    db_d    = db_q;
    dc_d    = dc_q;
    dhc_d   = dhc_q;
    dovf_d  = dovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (sig_START) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else if (sig_SRS) begin
            if (sig_SHAMT == '0) begin
              out_d  = reg_A;
              avr_d  = 1'b0;
              acr_d  = 1'b0;
              hc_d   = 1'b0;
              done_d = 1'b1;
            end else begin
              state_d = RUN_SR;
              cnt_d   = sig_SHAMT;
              work_d  = reg_A;
            end
`ifdef ALU_DECIMAL_EN
          end else if (sig_SUMS && sig_DAA) begin
            state_d = RUN_DEC;
            cnt_d   = SHW'(NumNib);
            work_d  = '0;
            da_d    = reg_A;
            db_d    = reg_B;
            dc_d    = sig_CARRY_IN;
            dovf_d  = bin_ovf;
`endif
          end else if (sig_SUMS) begin
            out_d  = bin_sum[WIDTH-1:0];
            acr_d  = bin_sum[WIDTH];
            avr_d  = bin_ovf;
            hc_d   = low_sum[4];
            done_d = 1'b1;
          end else begin
            if (sig_ANDS) begin
              out_d = reg_A & reg_B;
            end else if (sig_EORS) begin
              out_d = reg_A ^ reg_B;
            end else begin
              out_d = reg_A | reg_B;
            end
            avr_d  = 1'b0;
            acr_d  = 1'b0;
            hc_d   = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      RUN_SR: begin
        work_d = work_q >> 1;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          out_d   = work_q >> 1;
          acr_d   = work_q[0];
          avr_d   = 1'b0;
          hc_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef ALU_DECIMAL_EN
      RUN_DEC: begin
        work_d = dec_cat[WIDTH+3:4];
        da_d   = da_q >> 4;
        db_d   = db_q >> 4;
        dc_d   = nib_carry;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(NumNib)) begin
          dhc_d = nib_carry;
        end
        if (cnt_q == SHW'(1)) begin
          out_d   = dec_cat[WIDTH+3:4];
          acr_d   = nib_carry;
          avr_d   = dovf_q;
          // A single-nibble datapath finishes on its first step.
          hc_d    = (cnt_q == SHW'(NumNib)) ? nib_carry : dhc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sig_CLK) begin
    if (!sig_RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      avr_q   <= 1'b0;
      acr_q   <= 1'b0;
      hc_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_DECIMAL_EN
      da_q    <= '0;
      db_q    <= '0;
      dc_q    <= 1'b0;
      dhc_q   <= 1'b0;
      dovf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      avr_q   <= avr_d;
      acr_q   <= acr_d;
      hc_q    <= hc_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef ALU_DECIMAL_EN
      da_q    <= da_d;
      db_q    <= db_d;
      dc_q    <= dc_d;
      dhc_q   <= dhc_d;
      dovf_q  <= dovf_d;
`endif
    end
  end

  assign ALU_OUT  = out_q;
  assign sig_AVR  = avr_q;
  assign sig_ACR  = acr_q;
  assign sig_HC   = hc_q;
  assign sig_BUSY = (state_q != IDLE);
  assign sig_DONE = done_q;
  assign sig_ERR  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vectors plus random ops, checked by a
// scoreboard. Expected results are queued at issue; a monitor pops on sig_DONE
// and also checks that outputs hold between completions.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int SHW = 3;

  localparam int OpAdd = 0;
  localparam int OpAnd = 1;
  localparam int OpEor = 2;
  localparam int OpOr  = 3;
  localparam int OpSr  = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         avr;
    logic         acr;
    logic         hc;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           sums = 1'b0, ands = 1'b0, eors = 1'b0, ors = 1'b0, srs = 1'b0;
  logic           daa = 1'b0;
  logic           cin = 1'b0;
  logic [SHW-1:0] shamt = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic [W-1:0]   alu_out;
  logic           avr, acr, hc, busy, done, err;

  int   errors = 0;
  int   checks = 0;
  res_t sb_q[$];

  alu_seq #(
    .WIDTH(W),
    .SHW  (SHW)
  ) dut (
    .sig_CLK     (clk),
    .sig_RST_N   (rst_n),
    .sig_START   (start),
    .sig_SUMS    (sums),
    .sig_ANDS    (ands),
    .sig_EORS    (eors),
    .sig_ORS     (ors),
    .sig_SRS     (srs),
    .sig_DAA     (daa),
    .sig_CARRY_IN(cin),
    .sig_SHAMT   (shamt),
    .reg_A       (a),
    .reg_B       (b),
    .ALU_OUT     (alu_out),
    .sig_AVR     (avr),
    .sig_ACR     (acr),
    .sig_HC      (hc),
    .sig_BUSY    (busy),
    .sig_DONE    (done),
    .sig_ERR     (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic void model(input int op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic c, input logic dm, input logic [SHW-1:0] sh,
                                output res_t r, output int lat);
    int va, vb, s, sa, sbv, ss, carry, d, n;
    va = int'(ia);
    vb = int'(ib);
    r = '0;
    lat = 1;
    if (op == OpAnd) r.out = ia & ib;
    else if (op == OpEor) r.out = ia ^ ib;
    else if (op == OpOr) r.out = ia | ib;
    else if (op == OpSr) begin
      n = int'(sh);
      r.out = ia >> n;
      r.acr = (n == 0) ? 1'b0 : 1'(((va >> (n - 1)) & 1));
      lat = (n == 0) ? 1 : n + 1;
    end else begin
      s = va + vb + int'(c);
      sa = (va >= (1 << (W - 1))) ? va - (1 << W) : va;
      sbv = (vb >= (1 << (W - 1))) ? vb - (1 << W) : vb;
      ss = sa + sbv + int'(c);
      r.avr = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
      r.out = W'(s % (1 << W));
      r.acr = (s >= (1 << W));
      r.hc = ((va % 16) + (vb % 16) + int'(c)) >= 16;
`ifdef ALU_DECIMAL_EN
      if (dm) begin
        carry = int'(c);
        s = 0;
        for (int i = 0; i < W / 4; i++) begin
          d = ((va >> (4 * i)) % 16) + ((vb >> (4 * i)) % 16) + carry;
          if (d > 9) begin
            d = (d + 6) % 16;
            carry = 1;
          end else carry = 0;
          s += d << (4 * i);
          if (i == 0) r.hc = 1'(carry);
        end
        r.out = W'(s);
        r.acr = 1'(carry);
        lat = W / 4 + 1;
      end
`else
      if (dm) lat = 1;
`endif
    end
  endfunction

  // Issue one legal op, entered between a negedge and the next posedge.
  // Returns at the negedge where sig_DONE is seen (or the wait bound expires).
  task automatic run_op(input int op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic c, input logic dm, input logic [SHW-1:0] sh,
                        input bit poke, input string tag);
    res_t e;
    int   exp_lat, lat, busy_n;
    bit   seen;
    model(op, ia, ib, c, dm, sh, e, exp_lat);
    sb_q.push_back(e);
    a = ia; b = ib; cin = c; daa = dm; shamt = sh;
    sums = (op == OpAdd); ands = (op == OpAnd); eors = (op == OpEor);
    ors = (op == OpOr); srs = (op == OpSr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    {sums, ands, eors, ors, srs} = 5'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); shamt = SHW'($urandom);
    lat = 0; busy_n = 0; seen = 0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) seen = 1;
      if (poke && !seen) begin
        chk({tag, " no err while busy"}, 32'(err), 32'd0);
        if (lat < 3) begin
          start = 1'b1; ands = 1'b1; a = W'($urandom); b = W'($urandom);
        end else begin
          start = 1'b0; ands = 1'b0;
        end
      end
    end
    start = 1'b0; ands = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
  endtask

  task automatic illegal(input logic [4:0] sel, input string tag);
    {sums, ands, eors, ors, srs} = sel;
    a = W'($urandom); b = W'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    {sums, ands, eors, ors, srs} = 5'b0;
    @(negedge clk);
    chk({tag, " err pulse"}, 32'(err), 32'd1);
    chk({tag, " not busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " err one cycle"}, 32'(err), 32'd0);
  endtask

  // Monitor: pop on DONE, otherwise outputs must hold the last completed result.
  initial begin
    res_t held, got, exp;
    held = '0;
    forever begin
      @(negedge clk);
      got = {alu_out, avr, acr, hc};
      if (!rst_n) begin
        held = '0;
        chk("reset outputs", 32'(got), 32'd0);
        chk("reset done", 32'(done), 32'd0);
      end else if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected done", 32'(done), 32'd0);
        end else begin
          exp = sb_q.pop_front();
          chk("result", 32'(got), 32'(exp));
          held = exp;
        end
      end else begin
        chk("hold", 32'(got), 32'(held));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         op;
    logic [4:0] sel;
    repeat (3) @(negedge clk);
    chk("rst out", 32'(alu_out), 32'd0);
    chk("rst flags", 32'({avr, acr, hc}), 32'd0);
    chk("rst busy/done/err", 32'({busy, done, err}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    run_op(OpAdd, 8'hF0, 8'h00, 1'b0, 1'b0, 3'd0, 0, "add F0");
    chk("add F0 vec", 32'({alu_out, avr, acr, hc}), 32'({8'hF0, 3'b000}));
    run_op(OpAdd, 8'hAB, 8'hF1, 1'b0, 1'b0, 3'd0, 0, "add AB");
    chk("add AB vec", 32'({alu_out, avr, acr, hc}), 32'({8'h9C, 3'b010}));
    run_op(OpAnd, 8'hAB, 8'hF1, 1'b0, 1'b0, 3'd0, 0, "and AB");
    chk("and AB vec", 32'(alu_out), 32'h A1);
    run_op(OpEor, 8'hAB, 8'hF1, 1'b0, 1'b0, 3'd0, 0, "eor AB");
    chk("eor AB vec", 32'(alu_out), 32'h5A);
    run_op(OpOr, 8'hAB, 8'hF1, 1'b0, 1'b0, 3'd0, 0, "or AB");
    chk("or AB vec", 32'(alu_out), 32'hFB);
    run_op(OpSr, 8'hAB, 8'h00, 1'b0, 1'b0, 3'd3, 0, "sr 3");
    chk("sr 3 vec", 32'({alu_out, acr}), 32'({8'h15, 1'b0}));
    run_op(OpSr, 8'hAB, 8'h00, 1'b0, 1'b0, 3'd0, 0, "sr 0");
    chk("sr 0 vec", 32'({alu_out, acr}), 32'({8'hAB, 1'b0}));
`ifdef ALU_DECIMAL_EN
    run_op(OpAdd, 8'h45, 8'h38, 1'b1, 1'b1, 3'd0, 0, "dec 45");
    chk("dec 45 vec", 32'({alu_out, acr, hc}), 32'({8'h84, 1'b0, 1'b1}));
    run_op(OpAdd, 8'h99, 8'h01, 1'b0, 1'b1, 3'd0, 0, "dec 99");
    chk("dec 99 vec", 32'({alu_out, acr}), 32'({8'h00, 1'b1}));
`else
    run_op(OpAdd, 8'h45, 8'h38, 1'b1, 1'b1, 3'd0, 0, "daa ignored");
    chk("daa ignored vec", 32'(alu_out), 32'h7E);
`endif

    illegal(5'b01010, "and+or");
    illegal(5'b00000, "no select");
    run_op(OpSr, 8'hC6, 8'h00, 1'b0, 1'b0, 3'd5, 1, "start while busy");

    // Abort a long shift with reset on its third busy cycle.
    a = 8'h5A; srs = 1'b1; shamt = 3'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; srs = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out", 32'(alu_out), 32'd0);
    #1 rst_n = 1'b1;
    repeat (9) @(negedge clk);
    run_op(OpAnd, 8'hFF, 8'h0F, 1'b0, 1'b0, 3'd0, 0, "and after abort");
    chk("and after abort vec", 32'(alu_out), 32'h0F);

    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 5));
      if (op == 5) begin
        do sel = 5'($urandom); while ($countones(sel) == 1);
        illegal(sel, "rand illegal");
      end else begin
        run_op(op, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
               SHW'($urandom), 0, "rand");
      end
    end

    repeat (4) @(negedge clk);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
